ex_sched: RTL
=============

Name: ex_sched

Overview:
- Execute-stage scheduler between issue and writeback.
- Accepts one pipeline_bus_t per handshake and routes it to the combinational single-cycle ALU or to an iterative radix-2 divider sub-module.
- Holds issue off while a divide is in flight and registers every result into one output slot with valid/ready backpressure.
- Implements DIV/DIVU/REM/REMU; all other ops go through the ALU unchanged.

Parameters:
XLEN, 32, datapath width; must match the width of rs1_data, rs2_data and rd_res in core::pipeline_bus_t.
DIV_ITERS, XLEN, number of divider iteration cycles (one quotient bit per cycle).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
flush_i  input  1  pipeline flush; kills in-flight and held work.
in_valid_i  input  1  issue presents ex_bus_i.
in_ready_o  output  1  scheduler accepts ex_bus_i this cycle.
ex_bus_i  input  pipeline_bus_t  instruction bus from issue.
alu_bus_o  output  pipeline_bus_t  bus driven into the ALU; equals ex_bus_i.
alu_bus_i  input  pipeline_bus_t  ALU combinational result bus.
out_valid_o  output  1  ex_bus_o holds a completed instruction.
out_ready_i  input  1  writeback consumes ex_bus_o.
ex_bus_o  output  pipeline_bus_t  registered result bus to writeback.
busy_o  output  1  divider in flight (state DIV_BUSY).

Behaviour:
- Reset values: state IDLE, out_valid_o=0, ex_bus_o all-zero, busy_o=0, iteration counter 0.
- Accept condition: accept = in_valid_i & in_ready_o.
- in_ready_o (combinational) = (state==IDLE) & (~out_valid_o | out_ready_i) & ~flush_i.
- Single-cycle op (alu_op not a div op):
  - On accept, ex_bus_o <= alu_bus_i and out_valid_o <= 1.
  - Latency 1; back-to-back issue gives one result per cycle.
- Div op (alu_op in {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}):
  - On accept, latch the bus and operands and go to DIV_BUSY.
  - Signed ops take magnitudes and record the result signs.
  - The divider runs DIV_ITERS cycles, then the result is written into ex_bus_o with rd_res = fixed-up quotient or remainder and rf_wr_en=1.
  - out_valid_o rises DIV_ITERS+1 cycles after the accept edge.
- Special cases, resolved in one cycle with no iterations (out_valid_o next cycle):
  - Divide by zero: quotient = all-ones (unsigned and signed); remainder = dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = -2^(XLEN-1); remainder = 0.
- States:
  - IDLE -> DIV_BUSY: accept of a div op that is not a special case.
  - DIV_BUSY -> DONE: after iteration DIV_ITERS-1.
  - DONE: in_ready_o=0. Writes ex_bus_o and sets out_valid_o when the output slot is empty or out_ready_i=1, then -> IDLE. Otherwise it waits in DONE.
- Output hold: while out_valid_o & ~out_ready_i, ex_bus_o and out_valid_o remain stable.
- Flush:
  - flush_i clears out_valid_o and aborts the divider; state -> IDLE at the next edge.
  - Flush beats accept in the same cycle.
  - Flush beats completion in the same cycle; no result emerges.
- Reset mid-divide: immediate return to reset values; no partial result is ever visible.
- Branch buses (is_branch=1): pass through like single-cycle ops, with the ALU's fields unmodified.
- Arithmetic width: remainder register is XLEN+1 bits; quotient shifts in from the LSB.

Decomposition:
- Package core gains:
  - alu_op enum members ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
  - ex_state_t enum {IDLE, DIV_BUSY, DONE}.
  - localparam DIV_CNT_W = $clog2(DIV_ITERS).
- Sub-module div_iter: restoring unsigned divider.
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Sign handling, special-case detection and sequencing stay in ex_sched.

Test Plan:
- ADD rs1=5, rs2=7, out_ready_i=1, three back-to-back issues -> rd_res=12 each; out_valid_o high on cycles 1, 2, 3; in_ready_o never drops.
- DIV rs1=-20, rs2=3 -> in_ready_o=0 and busy_o=1 for 32 cycles; out_valid_o at cycle 33 with rd_res=-6. REM on the same operands -> rd_res=-2.
- DIVU rs1=100, rs2=0 -> rd_res=32'hFFFFFFFF at cycle 1. REM rs1=-2^31, rs2=-1 -> rd_res=0 at cycle 1.
- DIVU 1000/7 completes while out_ready_i=0 for 5 cycles -> ex_bus_o stays at rd_res=142, in_ready_o=0; the next ADD is accepted only in the cycle out_ready_i rises.
- flush_i pulsed at iteration 10 of a DIV -> no out_valid_o; state IDLE next cycle; a subsequent XOR 0xF0^0x0F gives 0xFF at latency 1.
- rst_n deasserted mid-divide -> out_valid_o, busy_o and ex_bus_o are 0 immediately (asynchronous); normal operation after release.

Source files
------------

// File: rtl/ex_sched_pkg.sv
// Shared execute-stage types: ALU opcodes, scheduler states and the pipeline bus.
package core;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = XLEN;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        DONE
    } ex_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        alu_op_t         alu_op;
        logic [4:0]      rd_addr;
        logic            rf_wr_en;
        logic            is_branch;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] rd_res;
    } pipeline_bus_t;

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/ex_sched_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
module div_iter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DIV_ITERS);

    logic [XLEN:0]    rem_q;
    logic [XLEN:0]    rem_d;
    logic [XLEN:0]    src_rem;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  src_quo;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  src_dvs;
    logic [XLEN+1:0]  shifted;
    logic [XLEN+1:0]  diff;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             done_q;
    logic             last_iter;

    // One restoring step; on start the fresh operands feed the step so iteration 0 lands on the load edge
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[XLEN-1]};
        diff    = shifted - {2'b00, src_dvs};
        if (diff[XLEN+1]) begin
            rem_d = shifted[XLEN:0];
            quo_d = {src_quo[XLEN-2:0], 1'b0};
        end else begin
            rem_d = diff[XLEN:0];
            quo_d = {src_quo[XLEN-2:0], 1'b1};
        end
    end

    assign last_iter = run_q & (cnt_q == CNT_W'(DIV_ITERS - 1));

    // Iteration sequencing: load, step DIV_ITERS-1 more times, then hold the result with done set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= divisor;
            cnt_q  <= CNT_W'(1);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (last_iter) begin
                cnt_q  <= '0;
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q[XLEN-1:0];

endmodule

// File: rtl/ex_sched.sv
// Execute-stage scheduler: routes issue to the ALU or the iterative divider and owns the output slot.
module ex_sched
    import core::*;
#(
    parameter int unsigned XLEN      = core::XLEN,
    parameter int unsigned DIV_ITERS = core::DIV_ITERS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  pipeline_bus_t ex_bus_i,
    output pipeline_bus_t alu_bus_o,
    input  pipeline_bus_t alu_bus_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output pipeline_bus_t ex_bus_o,
    output logic          busy_o
);

    ex_state_t       state_q;
    ex_state_t       state_d;
    logic            out_valid_q;
    logic            out_valid_d;
    pipeline_bus_t   out_bus_q;
    pipeline_bus_t   out_bus_d;
    pipeline_bus_t   div_bus_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            is_div;
    logic            signed_op;
    logic            rem_op;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic            div_done;
    logic            slot_free;
    logic            accept;
    logic            div_start;

    assign alu_bus_o = ex_bus_i;

    // Decode the issuing op: operand magnitudes, result signs and the no-iteration special cases
    always_comb begin
        is_div    = is_div_op(ex_bus_i.alu_op);
        signed_op = (ex_bus_i.alu_op == ALU_DIV) | (ex_bus_i.alu_op == ALU_REM);
        rem_op    = (ex_bus_i.alu_op == ALU_REM) | (ex_bus_i.alu_op == ALU_REMU);
        a_neg     = signed_op & ex_bus_i.rs1_data[XLEN-1];
        b_neg     = signed_op & ex_bus_i.rs2_data[XLEN-1];
        a_mag     = a_neg ? -ex_bus_i.rs1_data : ex_bus_i.rs1_data;
        b_mag     = b_neg ? -ex_bus_i.rs2_data : ex_bus_i.rs2_data;
        div_zero  = (ex_bus_i.rs2_data == '0);
        sgn_ovf   = signed_op & (ex_bus_i.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                              & (ex_bus_i.rs2_data == '1);
        special   = div_zero | sgn_ovf;
        if (div_zero) begin
            special_res = rem_op ? ex_bus_i.rs1_data : '1;
        end else begin
            special_res = rem_op ? '0 : ex_bus_i.rs1_data;
        end
    end

    assign slot_free  = ~out_valid_q | out_ready_i;
    assign in_ready_o = (state_q == IDLE) & slot_free & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;
    assign div_start  = accept & is_div & ~special;

    div_iter #(
        .XLEN      (XLEN),
        .DIV_ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush_i),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign fix-up of the unsigned divider result for the op that was latched at issue
    always_comb begin
        if ((div_bus_q.alu_op == ALU_REM) | (div_bus_q.alu_op == ALU_REMU)) begin
            div_res = neg_rem_q ? -div_rem : div_rem;
        end else begin
            div_res = neg_quo_q ? -div_quo : div_quo;
        end
    end

    // Next state and output-slot update; flush overrides both accept and completion
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_bus_d   = out_bus_q;
        if (out_valid_q & out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!is_div) begin
                            out_bus_d   = alu_bus_i;
                            out_valid_d = 1'b1;
                        end else if (special) begin
                            out_bus_d          = ex_bus_i;
                            out_bus_d.rd_res   = special_res;
                            out_bus_d.rf_wr_en = 1'b1;
                            out_valid_d        = 1'b1;
                        end else begin
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (div_done) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (slot_free) begin
                        out_bus_d          = div_bus_q;
                        out_bus_d.rd_res   = div_res;
                        out_bus_d.rf_wr_en = 1'b1;
                        out_valid_d        = 1'b1;
                        state_d            = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_bus_q   <= out_bus_d;
        end
    end

    // Capture the dividing instruction and its result signs at issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_bus_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (div_start) begin
            div_bus_q <= ex_bus_i;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end
    end

    assign out_valid_o = out_valid_q;
    assign ex_bus_o    = out_bus_q;
    assign busy_o      = (state_q == DIV_BUSY);

endmodule
